// File: rtl/pf_ram_pkg.sv
// Shared types and defaults for the multi-lane playfield RAM.
package pf_ram_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } pf_clr_state_t;

  localparam int PF_LANES = 4;
  localparam int PF_DW    = 8;
  localparam int PF_AW    = 8;

  function automatic logic [7:0] lane_off(input int unsigned n);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pf_ram_lane.sv
// One playfield lane: single write port, registered reads on A and B.
// PF_RAM_FWD_EN selects write-first forwarding on the B read.
module pf_ram_lane
  import pf_ram_pkg::*;
#(
  parameter int DW = PF_DW,
  parameter int AW = PF_AW
) (
  input  logic          clk_a,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          zero_i,
  input  logic          re_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic          re_b_i,
  input  logic [AW-1:0] addr_b_i,
  output logic [DW-1:0] dout_a_o,
  output logic [DW-1:0] dout_b_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_a_q;
  logic [DW-1:0] dout_b_q;
  logic [DW-1:0] rd_b;

  always_ff @(posedge clk_a) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

`ifdef PF_RAM_FWD_EN
  assign rd_b = (we_i && (waddr_i == addr_b_i)) ? wdata_i
                                                : mem_q[addr_b_i];
`else
  assign rd_b = mem_q[addr_b_i];
`endif

  always_ff @(posedge clk_a) begin
    if (reset || zero_i) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      if (re_a_i) dout_a_q <= mem_q[addr_a_i];
      if (re_b_i) dout_b_q <= rd_b;
    end
  end

  assign dout_a_o = dout_a_q;
  assign dout_b_o = dout_b_q;

endmodule

// File: rtl/pf_ram_lanes.sv
// Multi-lane playfield RAM top: clear FSM, write-source mux, A select.
// Optional macro PF_RAM_FWD_EN enables port B write-first forwarding.
module pf_ram_lanes
  import pf_ram_pkg::*;
#(
  parameter int             LANES     = PF_LANES,
  parameter int             DW        = PF_DW,
  parameter int             AW        = PF_AW,
  parameter logic [DW-1:0]  CLEAR_VAL = '0
) (
  input  logic                clk_a,
  input  logic                reset,
  input  logic                clear_req,
  output logic                busy,
  input  logic [AW-1:0]       addr_a,
  input  logic [DW-1:0]       din_a,
  input  logic [LANES-1:0]    ce_a_n,
  input  logic [LANES-1:0]    we_a_n,
  output logic [DW-1:0]       dout_a,
  input  logic [AW-1:0]       addr_b,
  input  logic [LANES-1:0]    ce_b_n,
  output logic [LANES*DW-1:0] dout_b,
  output logic                vld_b
);

  localparam logic [7:0] OFF8 = lane_off(LANES);
  localparam logic [LANES-1:0] OFF = OFF8[LANES-1:0];

  pf_clr_state_t state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [LANES-1:0] sel_q;
  logic vld_b_q;

  logic [LANES-1:0] lane_we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [DW-1:0]    lane_a [LANES];

  assign busy = (state_q == CLR_RUN);

  always_ff @(posedge clk_a) begin
    if (reset) begin
      state_q    <= CLR_RUN;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    unique case (state_q)
      CLR_RUN: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == '1) state_d = CLR_IDLE;
      end
      CLR_IDLE: begin
        if (clear_req) begin
          state_d    = CLR_RUN;
          clr_addr_d = '0;
        end
      end
      default: state_d = CLR_RUN;
    endcase
  end

  // Engine owns the array while busy; reset blocks every write.
  always_comb begin
    lane_we = '0;
    wr_addr = addr_a;
    wr_data = din_a;
    if (!reset) begin
      if (busy) begin
        lane_we = '1;
        wr_addr = clr_addr_q;
        wr_data = CLEAR_VAL;
      end else begin
        lane_we = ~we_a_n;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pf_ram_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk_a    (clk_a),
      .reset    (reset),
      .we_i     (lane_we[g]),
      .waddr_i  (wr_addr),
      .wdata_i  (wr_data),
      .zero_i   (busy),
      .re_a_i   (~ce_a_n[g] & we_a_n[g]),
      .addr_a_i (addr_a),
      .re_b_i   (~ce_b_n[g]),
      .addr_b_i (addr_b),
      .dout_a_o (lane_a[g]),
      .dout_b_o (dout_b[g*DW +: DW])
    );
  end

  always_ff @(posedge clk_a) begin
    if (reset) begin
      sel_q   <= OFF;
      vld_b_q <= 1'b0;
    end else begin
      sel_q   <= ce_a_n;
      vld_b_q <= !busy && (ce_b_n != OFF);
    end
  end

  // Later iterations win, so the highest enabled lane takes priority.
  always_comb begin
    dout_a = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!sel_q[i]) dout_a = lane_a[i];
    end
  end

  assign vld_b = vld_b_q;

endmodule

// File: doc/pf_ram_lanes.md
# pf_ram_lanes

Parametrised multi-lane playfield RAM: `LANES` independent `DW`-bit lanes, each `2**AW` deep, sharing one address per port. Port A is the CPU-side read/write path. It is byte-lane addressed, active-low enables, `DW` bits wide. Port B is the video-side read path, returning all lanes as one `LANES*DW` word. It is the next generation of the playfield store and adds three things:
- single-clock registered reads on both ports,
- a hardware clear engine that sweeps the whole array after reset or on request,
- optional write-to-read forwarding on port B.

## Interface
Parameters:
- `LANES`, 4, number of lanes (1..8)
- `DW`, 8, lane data width
- `AW`, 8, address width; depth `2**AW`
- `CLEAR_VAL`, 0, `DW`-bit value written by the clear engine

Ports:
- `clk_a`  in  1  single clock for both ports and the clear engine
- `reset`  in  1  synchronous, active-high
- `clear_req`  in  1  pulse; starts a full-array clear when idle
- `busy`  out  1  high while the clear engine owns the array
- `addr_a`  in  `AW`  port A address
- `din_a`  in  `DW`  port A write data
- `ce_a_n`  in  `LANES`  port A lane enables, active-low
- `we_a_n`  in  `LANES`  port A lane write enables, active-low
- `dout_a`  out  `DW`  port A read data, registered
- `addr_b`  in  `AW`  port B address
- `ce_b_n`  in  `LANES`  port B lane enables, active-low
- `dout_b`  out  `LANES*DW`  port B read data, lane i at bits `[i*DW +: DW]`
- `vld_b`  out  1  port B read data valid

## Operation
Port A:
- A lane is written when `we_a_n[i]=0`, with `din_a` written to `lane[i][addr_a]`.
- A lane is read when `ce_a_n[i]=0` and `we_a_n[i]=1`. The registered per-lane copy updates; all other lanes hold.
- `dout_a` is a mux of the registered per-lane copies. The select is registered from `ce_a_n` and prioritises the highest active lane (`LANES-1` first). When no lane was enabled, `dout_a=0`.
- Multiple active write lanes: all are written with `din_a`.

Port B:
- Lane i's output register loads `lane[i][addr_b]` when `ce_b_n[i]=0`; otherwise it holds.
- `vld_b` is registered from `ce_b_n != all-ones`.

Clear engine, with states `CLR_IDLE` and `CLR_RUN` and an `AW`-bit counter `clr_addr`:
- Reset forces `CLR_RUN` with `clr_addr=0`. No array writes happen while `reset=1`.
- `CLR_RUN`: each cycle, writes `CLEAR_VAL` to all lanes at `clr_addr`, then increments `clr_addr`.
  - At `clr_addr=2**AW-1`, the state goes to `CLR_IDLE` after that write.
- `CLR_IDLE` + `clear_req=1`: the state goes to `CLR_RUN` with `clr_addr=0`.
- `clear_req` during `CLR_RUN` is ignored. The sweep does not restart.
- `busy = (state==CLR_RUN)`.
- While `busy`:
  - port A writes are dropped;
  - port A and port B read registers load 0;
  - `vld_b=0`.
- `reset` mid-sweep restarts the sweep from address 0 after `reset` falls.

Collisions:
- Port A write and port A read to the same lane cannot occur, because `we` takes precedence and the read register holds.
- Port A write and port B read to the same address/lane in the same cycle: see Configuration.

## Timing
- Reset values: `dout_a=0`, `dout_b=0`, `vld_b=0`, `busy=1`.
- Port A read latency is 1 cycle. A write is visible to a port A read issued the next cycle.
- Port B read latency is 1 cycle. `vld_b` aligns with `dout_b`.
- A clear takes exactly `2**AW` cycles.
  - `busy` rises the cycle after `clear_req` is sampled in `CLR_IDLE`.
  - `busy` falls the cycle after the last address is written.
  - The first port A write is accepted in the cycle `busy=0`.
- After `reset` is released, `busy` remains 1 for `2**AW` cycles.

## Configuration
- `PF_RAM_FWD_EN` defined: on a same-cycle port A write and port B read of the same address and lane, `dout_b` for that lane returns `din_a` (write-first).
- `PF_RAM_FWD_EN` undefined: that lane returns the old contents (read-first). This lets the block infer plain block RAM with no bypass mux.
- The clear engine is unaffected by the macro. Clear writes are never forwarded, because port B reads 0 while `busy`.

## Structure
- Package `pf_ram_pkg`:
  - state typedef `pf_clr_state_t` (`CLR_IDLE`, `CLR_RUN`);
  - default constants `PF_LANES=4`, `PF_DW=8`, `PF_AW=8`;
  - function `lane_off(n)` returning the all-ones enable mask.
- Sub-module `pf_ram_lane`: one `DW x 2**AW` lane with one write port, port A and port B registered reads, and the forward mux under `PF_RAM_FWD_EN`. It is instantiated `LANES` times by generate.
- The top level holds the clear FSM, the write-source mux (engine vs port A) and the port A output select.

## Test plan
- Reset for 3 cycles, release -> `busy=1` for exactly 256 cycles (`AW=8`); then port B reads of addresses 0x00 and 0xFF -> `dout_b=0`, `vld_b=1`.
- Write 0xA5 to lane 2 at addr 0x3C (`we_a_n=4'b1011`), then read with `ce_a_n=4'b1011` -> `dout_a=0xA5` one cycle later; port B read of 0x3C -> `dout_b=0x00A50000`.
- Read with `ce_a_n=4'b0101` after writing 0x11 to lane 1 and 0x77 to lane 3 at addr 0x10 -> `dout_a=0x77` (lane 3 priority).
- Same-cycle port A write of 0x5A to lane 0, addr 0x20 (old value 0x00) with a port B read of 0x20 -> lane 0 of `dout_b` is 0x5A with `PF_RAM_FWD_EN`, 0x00 without.
- `clear_req` pulse with the array full of 0xFF, then a port A write attempted at cycle 10 of the sweep -> dropped; after `busy` falls, every address reads 0; a second `clear_req` mid-sweep does not extend `busy` past 256 cycles.
- `reset` asserted at cycle 100 of a sweep -> after release, `busy` stays 1 for a full 256 cycles.
